// File: rtl/fft_pkg.sv
// Shared constants and encodings for the FFT output sort buffer.
// Optional build macro: SORT_INDEX_OUT_EN (adds dout_num output).
package fft_pkg;

   localparam int FFT_LOG2 = 4;
   localparam int FFT_N    = 1 << FFT_LOG2;

   typedef enum logic {
      BANK_A = 1'b0,
      BANK_B = 1'b1
   } bank_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } rd_st_e;

   function automatic bank_e other_bank(input bank_e b);
      return (b == BANK_A) ? BANK_B : BANK_A;
   endfunction

endpackage

// File: rtl/fft_sort_bank.sv
// One frame of sample storage: sync write port, async read port.
// Contents are deliberately never reset.
module fft_sort_bank
   import fft_pkg::*;
#(
   parameter int W  = 48,
   parameter int AW = FFT_LOG2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [1<<AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_sort_buffer.sv
// Ping-pong reorder buffer: bit-reversed FFT bins in, natural order out.
// Optional build macro: SORT_INDEX_OUT_EN (adds dout_num output).
module fft_sort_buffer
   import fft_pkg::*;
#(
   parameter int WIDTH     = 24,
   parameter int PointLog2 = FFT_LOG2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic [WIDTH-1:0]     din_r,
   input  logic [WIDTH-1:0]     din_i,
   input  logic [PointLog2-1:0] d_num,
   output logic                 dout_valid,
   output logic [WIDTH-1:0]     dout_r,
   output logic [WIDTH-1:0]     dout_i,
   output logic                 frame_done
`ifdef SORT_INDEX_OUT_EN
   ,
   output logic [PointLog2-1:0] dout_num
`endif
);

   localparam logic [PointLog2-1:0] LAST =
      PointLog2'((1 << PointLog2) - 1);

   logic [PointLog2-1:0] wr_cnt_q, wr_cnt_d;
   bank_e                wr_bank_q, wr_bank_d;
   bank_e                rd_bank_q, rd_bank_d;
   rd_st_e               state_q, state_d;
   logic [PointLog2-1:0] rd_addr_q, rd_addr_d;
   logic                 dout_valid_q, dout_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic [WIDTH-1:0]     dout_r_q, dout_r_d;
   logic [WIDTH-1:0]     dout_i_q, dout_i_d;

   logic                 frame_end;
   logic                 we_a, we_b;
   logic [2*WIDTH-1:0]   wdata, rdata_a, rdata_b, rdata;

   assign wdata = {din_r, din_i};
   assign we_a  = din_valid && !rst && (wr_bank_q == BANK_A);
   assign we_b  = din_valid && !rst && (wr_bank_q == BANK_B);
   assign rdata = (rd_bank_q == BANK_A) ? rdata_a : rdata_b;

   fft_sort_bank #(.W(2*WIDTH), .AW(PointLog2)) u_bank_a (
      .clk   (clk),
      .we    (we_a),
      .waddr (d_num),
      .wdata (wdata),
      .raddr (rd_addr_q),
      .rdata (rdata_a)
   );

   fft_sort_bank #(.W(2*WIDTH), .AW(PointLog2)) u_bank_b (
      .clk   (clk),
      .we    (we_b),
      .waddr (d_num),
      .wdata (wdata),
      .raddr (rd_addr_q),
      .rdata (rdata_b)
   );

   // Frames are delimited by beat count, not by which indices arrived.
   assign frame_end = din_valid && (wr_cnt_q == LAST);

   always_comb begin
      wr_cnt_d     = wr_cnt_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      dout_valid_d = 1'b0;
      frame_done_d = 1'b0;
      dout_r_d     = dout_r_q;
      dout_i_d     = dout_i_q;

      if (din_valid) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if (frame_end) begin
         wr_bank_d = other_bank(wr_bank_q);
      end

      if (state_q == ST_READ) begin
         dout_valid_d         = 1'b1;
         {dout_r_d, dout_i_d} = rdata;
         frame_done_d         = (rd_addr_q == LAST);
         rd_addr_d            = rd_addr_q + 1'b1;
         if (rd_addr_q == LAST) begin
            state_d = ST_IDLE;
         end
      end

      // A completing frame restarts the drain with no bubble.
      if (frame_end) begin
         state_d   = ST_READ;
         rd_addr_d = '0;
         rd_bank_d = wr_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q     <= '0;
         wr_bank_q    <= BANK_A;
         rd_bank_q    <= BANK_A;
         state_q      <= ST_IDLE;
         rd_addr_q    <= '0;
         dout_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         dout_r_q     <= '0;
         dout_i_q     <= '0;
      end else begin
         wr_cnt_q     <= wr_cnt_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         dout_valid_q <= dout_valid_d;
         frame_done_q <= frame_done_d;
         dout_r_q     <= dout_r_d;
         dout_i_q     <= dout_i_d;
      end
   end

   assign dout_valid = dout_valid_q;
   assign frame_done = frame_done_q;
   assign dout_r     = dout_r_q;
   assign dout_i     = dout_i_q;

`ifdef SORT_INDEX_OUT_EN
   logic [PointLog2-1:0] dout_num_q, dout_num_d;

   always_comb begin
      dout_num_d = dout_num_q;
      if (state_q == ST_READ) begin
         dout_num_d = rd_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_num_q <= '0;
      end else begin
         dout_num_q <= dout_num_d;
      end
   end

   assign dout_num = dout_num_q;
`endif

endmodule
